// File: rtl/rgb_pixel_assembler_if.sv
// Byte-stream input and tagged-pixel output of the RGB pixel assembler.
// The master drives the serial byte stream; the slave (assembler) returns pixels.
interface rgb_pixel_assembler_if #(
    parameter int unsigned XW = 10,
    parameter int unsigned YW = 9
);
    logic [7:0]    in_data;
    logic          in_valid;
    logic          eof;
    logic [23:0]   pix_rgb;
    logic          pix_valid;
    logic [XW-1:0] pix_x;
    logic [YW-1:0] pix_y;
    logic          sof;
    logic          eol;
    logic          frame_done;
    logic          done;
    logic          frame_err;

    modport master (
        output in_data, in_valid, eof,
        input  pix_rgb, pix_valid, pix_x, pix_y, sof, eol, frame_done, done, frame_err
    );

    modport slave (
        input  in_data, in_valid, eof,
        output pix_rgb, pix_valid, pix_x, pix_y, sof, eol, frame_done, done, frame_err
    );
endinterface

// File: rtl/rgb_pixel_assembler.sv
// Packs a byte-serial R,G,B stream into 24-bit pixels tagged with raster position,
// start-of-frame / end-of-line / frame-done flags, and stops at end-of-file.
module rgb_pixel_assembler #(
    parameter int unsigned IMG_WIDTH  = 640,
    parameter int unsigned IMG_HEIGHT = 480,
    parameter int unsigned XW         = 10,
    parameter int unsigned YW         = 9
) (
    input logic                  clk,
    input logic                  rst,
    rgb_pixel_assembler_if.slave bus
);
    localparam logic [XW-1:0] XMax = XW'(IMG_WIDTH - 1);
    localparam logic [YW-1:0] YMax = YW'(IMG_HEIGHT - 1);

    typedef enum logic [0:0] {StRun, StDone} state_e;

    state_e        state_q, state_d;
    logic [1:0]    phase_q, phase_d;
    logic [7:0]    r_q, r_d, g_q, g_d;
    logic [XW-1:0] x_q, x_d, pix_x_q, pix_x_d;
    logic [YW-1:0] y_q, y_d, pix_y_q, pix_y_d;
    logic [23:0]   pix_rgb_q, pix_rgb_d;
    logic          pix_valid_q, pix_valid_d;
    logic          sof_q, sof_d, eol_q, eol_d, frame_done_q, frame_done_d;
    logic          done_q, done_d, frame_err_q, frame_err_d;
    logic          accept;

    assign accept = (state_q == StRun) && bus.in_valid && !bus.eof;

    always_comb begin
        state_d      = state_q;
        phase_d      = phase_q;
        r_d          = r_q;
        g_d          = g_q;
        x_d          = x_q;
        y_d          = y_q;
        pix_x_d      = pix_x_q;
        pix_y_d      = pix_y_q;
        pix_rgb_d    = pix_rgb_q;
        pix_valid_d  = 1'b0;
        sof_d        = 1'b0;
        eol_d        = 1'b0;
        frame_done_d = 1'b0;
        done_d       = done_q;
        frame_err_d  = frame_err_q;

        if (state_q == StRun && bus.eof) begin
            // Any byte arriving alongside eof is dropped, even a completing B byte.
            state_d = StDone;
            done_d  = 1'b1;
            if (phase_q != 2'd0 || x_q != '0 || y_q != '0) begin
                frame_err_d = 1'b1;
            end
        end else if (accept) begin
            case (phase_q)
                2'd0: begin
                    r_d     = bus.in_data;
                    phase_d = 2'd1;
                end
                2'd1: begin
                    g_d     = bus.in_data;
                    phase_d = 2'd2;
                end
                default: begin
                    phase_d      = 2'd0;
                    pix_rgb_d    = {r_q, g_q, bus.in_data};
                    pix_valid_d  = 1'b1;
                    pix_x_d      = x_q;
                    pix_y_d      = y_q;
                    sof_d        = (x_q == '0) && (y_q == '0);
                    eol_d        = (x_q == XMax);
                    frame_done_d = (x_q == XMax) && (y_q == YMax);
                    if (x_q == XMax) begin
                        x_d = '0;
                        y_d = (y_q == YMax) ? '0 : y_q + YW'(1);
                    end else begin
                        x_d = x_q + XW'(1);
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StRun;
            phase_q      <= 2'd0;
            r_q          <= '0;
            g_q          <= '0;
            x_q          <= '0;
            y_q          <= '0;
            pix_x_q      <= '0;
            pix_y_q      <= '0;
            pix_rgb_q    <= '0;
            pix_valid_q  <= 1'b0;
            sof_q        <= 1'b0;
            eol_q        <= 1'b0;
            frame_done_q <= 1'b0;
            done_q       <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            phase_q      <= phase_d;
            r_q          <= r_d;
            g_q          <= g_d;
            x_q          <= x_d;
            y_q          <= y_d;
            pix_x_q      <= pix_x_d;
            pix_y_q      <= pix_y_d;
            pix_rgb_q    <= pix_rgb_d;
            pix_valid_q  <= pix_valid_d;
            sof_q        <= sof_d;
            eol_q        <= eol_d;
            frame_done_q <= frame_done_d;
            done_q       <= done_d;
            frame_err_q  <= frame_err_d;
        end
    end

    assign bus.pix_rgb    = pix_rgb_q;
    assign bus.pix_valid  = pix_valid_q;
    assign bus.pix_x      = pix_x_q;
    assign bus.pix_y      = pix_y_q;
    assign bus.sof        = sof_q;
    assign bus.eol        = eol_q;
    assign bus.frame_done = frame_done_q;
    assign bus.done       = done_q;
    assign bus.frame_err  = frame_err_q;
endmodule

// File: tb/tb_rgb_pixel_assembler.sv
// Directed bench for rgb_pixel_assembler on a 4x2 frame; outputs sampled 1ns after posedge.
module tb_rgb_pixel_assembler;
    localparam int unsigned W  = 4;
    localparam int unsigned H  = 2;
    localparam int unsigned XW = 10;
    localparam int unsigned YW = 9;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;

    rgb_pixel_assembler_if #(.XW(XW), .YW(YW)) bus ();

    rgb_pixel_assembler #(
        .IMG_WIDTH (W),
        .IMG_HEIGHT(H),
        .XW        (XW),
        .YW        (YW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic drive(input logic [7:0] d, input logic v, input logic e);
        bus.in_data  = d;
        bus.in_valid = v;
        bus.eof      = e;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive(8'h00, 1'b0, 1'b0);
        drive(8'h00, 1'b0, 1'b0);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (bus.pix_valid !== 1'b0 || bus.pix_rgb !== 24'h0 || bus.sof !== 1'b0
            || bus.eol !== 1'b0 || bus.frame_done !== 1'b0) begin
            failures++;
            $display("FAIL reset_pix got v=%b rgb=%h sof=%b eol=%b fd=%b exp all 0",
                     bus.pix_valid, bus.pix_rgb, bus.sof, bus.eol, bus.frame_done);
        end
        checks++;
        if (bus.done !== 1'b0 || bus.frame_err !== 1'b0 || bus.pix_x !== '0 || bus.pix_y !== '0)
        begin
            failures++;
            $display("FAIL reset_status got done=%b err=%b x=%0d y=%0d exp 0",
                     bus.done, bus.frame_err, bus.pix_x, bus.pix_y);
        end
    endtask

    task automatic test_single_pixel();
        do_reset();
        drive(8'h11, 1'b1, 1'b0);
        drive(8'h22, 1'b1, 1'b0);
        checks++;
        if (bus.pix_valid !== 1'b0) begin
            failures++;
            $display("FAIL single_early_valid got %b exp 0", bus.pix_valid);
        end
        drive(8'h33, 1'b1, 1'b0);
        checks++;
        if (bus.pix_valid !== 1'b1 || bus.pix_rgb !== 24'h112233) begin
            failures++;
            $display("FAIL single_pix got v=%b rgb=%h exp v=1 rgb=112233",
                     bus.pix_valid, bus.pix_rgb);
        end
        checks++;
        if (bus.pix_x !== 10'd0 || bus.pix_y !== 9'd0 || bus.sof !== 1'b1 || bus.eol !== 1'b0)
        begin
            failures++;
            $display("FAIL single_tags got x=%0d y=%0d sof=%b eol=%b exp 0 0 1 0",
                     bus.pix_x, bus.pix_y, bus.sof, bus.eol);
        end
        drive(8'h00, 1'b0, 1'b0);
        checks++;
        if (bus.pix_valid !== 1'b0 || bus.sof !== 1'b0 || bus.pix_rgb !== 24'h112233) begin
            failures++;
            $display("FAIL single_strobe got v=%b sof=%b rgb=%h exp v=0 sof=0 rgb=112233",
                     bus.pix_valid, bus.sof, bus.pix_rgb);
        end
    endtask

    // Nine pixels: a full 4x2 frame then the first pixel of the next frame.
    task automatic test_frame();
        logic [23:0] prev;
        do_reset();
        prev = 24'h0;
        for (int p = 0; p < 9; p++) begin
            logic [7:0]    r, g, b;
            logic [XW-1:0] ex;
            logic [YW-1:0] ey;
            logic          esof, eeol, efd;
            r    = 8'(p);
            g    = 8'(p + 16);
            b    = 8'(p + 32);
            ex   = XW'(p % 4);
            ey   = YW'((p / 4) % 2);
            esof = (p % 8 == 0);
            eeol = (p % 4 == 3);
            efd  = (p % 8 == 7);
            drive(r, 1'b1, 1'b0);
            checks++;
            if (bus.pix_valid !== 1'b0 || bus.pix_rgb !== prev) begin
                failures++;
                $display("FAIL frame_hold p=%0d got v=%b rgb=%h exp v=0 rgb=%h",
                         p, bus.pix_valid, bus.pix_rgb, prev);
            end
            drive(g, 1'b1, 1'b0);
            drive(b, 1'b1, 1'b0);
            prev = {r, g, b};
            checks++;
            if (bus.pix_valid !== 1'b1 || bus.pix_rgb !== prev) begin
                failures++;
                $display("FAIL frame_pix p=%0d got v=%b rgb=%h exp v=1 rgb=%h",
                         p, bus.pix_valid, bus.pix_rgb, prev);
            end
            checks++;
            if (bus.pix_x !== ex || bus.pix_y !== ey || bus.sof !== esof || bus.eol !== eeol
                || bus.frame_done !== efd) begin
                failures++;
                $display("FAIL frame_tags p=%0d got x=%0d y=%0d sof=%b eol=%b fd=%b exp %0d %0d %b %b %b",
                         p, bus.pix_x, bus.pix_y, bus.sof, bus.eol, bus.frame_done,
                         ex, ey, esof, eeol, efd);
            end
        end
    endtask

    task automatic test_gaps();
        do_reset();
        drive(8'h11, 1'b1, 1'b0);
        drive(8'hFF, 1'b0, 1'b0);
        drive(8'h22, 1'b1, 1'b0);
        drive(8'hEE, 1'b0, 1'b0);
        checks++;
        if (bus.pix_valid !== 1'b0) begin
            failures++;
            $display("FAIL gaps_spurious got %b exp 0", bus.pix_valid);
        end
        drive(8'hDD, 1'b0, 1'b0);
        drive(8'h33, 1'b1, 1'b0);
        checks++;
        if (bus.pix_valid !== 1'b1 || bus.pix_rgb !== 24'h112233 || bus.pix_x !== 10'd0
            || bus.pix_y !== 9'd0) begin
            failures++;
            $display("FAIL gaps_pix got v=%b rgb=%h x=%0d y=%0d exp 1 112233 0 0",
                     bus.pix_valid, bus.pix_rgb, bus.pix_x, bus.pix_y);
        end
    endtask

    task automatic test_eof_clean();
        do_reset();
        for (int i = 0; i < 24; i++) drive(8'(i), 1'b1, 1'b0);
        checks++;
        if (bus.frame_done !== 1'b1 || bus.done !== 1'b0 || bus.pix_rgb !== 24'h151617) begin
            failures++;
            $display("FAIL eofc_last got fd=%b done=%b rgb=%h exp 1 0 151617",
                     bus.frame_done, bus.done, bus.pix_rgb);
        end
        drive(8'h00, 1'b0, 1'b1);
        checks++;
        if (bus.done !== 1'b1 || bus.frame_err !== 1'b0) begin
            failures++;
            $display("FAIL eofc_done got done=%b err=%b exp 1 0", bus.done, bus.frame_err);
        end
        for (int i = 0; i < 4; i++) begin
            drive(8'hA0 + 8'(i), 1'b1, 1'(i == 2));
            checks++;
            if (bus.pix_valid !== 1'b0 || bus.done !== 1'b1 || bus.frame_err !== 1'b0) begin
                failures++;
                $display("FAIL eofc_after i=%0d got v=%b done=%b err=%b exp 0 1 0",
                         i, bus.pix_valid, bus.done, bus.frame_err);
            end
        end
    endtask

    task automatic test_eof_short();
        do_reset();
        drive(8'h01, 1'b1, 1'b0);
        drive(8'h02, 1'b1, 1'b0);
        drive(8'h03, 1'b1, 1'b0);
        drive(8'h00, 1'b0, 1'b1);
        checks++;
        if (bus.done !== 1'b1 || bus.frame_err !== 1'b1) begin
            failures++;
            $display("FAIL eofs got done=%b err=%b exp 1 1", bus.done, bus.frame_err);
        end
    endtask

    task automatic test_eof_partial();
        do_reset();
        drive(8'h11, 1'b1, 1'b0);
        drive(8'h22, 1'b1, 1'b0);
        drive(8'h33, 1'b1, 1'b1);
        checks++;
        if (bus.pix_valid !== 1'b0 || bus.pix_rgb !== 24'h0 || bus.done !== 1'b1
            || bus.frame_err !== 1'b1) begin
            failures++;
            $display("FAIL eofp got v=%b rgb=%h done=%b err=%b exp 0 000000 1 1",
                     bus.pix_valid, bus.pix_rgb, bus.done, bus.frame_err);
        end
        drive(8'h44, 1'b1, 1'b0);
        checks++;
        if (bus.pix_valid !== 1'b0 || bus.done !== 1'b1 || bus.frame_err !== 1'b1) begin
            failures++;
            $display("FAIL eofp_sticky got v=%b done=%b err=%b exp 0 1 1",
                     bus.pix_valid, bus.done, bus.frame_err);
        end
    endtask

    // Entered with done/frame_err set by the previous test; reset must clear them.
    task automatic test_rst_mid();
        do_reset();
        drive(8'h11, 1'b1, 1'b0);
        drive(8'h22, 1'b1, 1'b0);
        do_reset();
        drive(8'hAA, 1'b1, 1'b0);
        drive(8'hBB, 1'b1, 1'b0);
        drive(8'hCC, 1'b1, 1'b0);
        checks++;
        if (bus.pix_valid !== 1'b1 || bus.pix_rgb !== 24'hAABBCC || bus.pix_x !== 10'd0
            || bus.pix_y !== 9'd0 || bus.sof !== 1'b1) begin
            failures++;
            $display("FAIL rstmid_pix got v=%b rgb=%h x=%0d y=%0d sof=%b exp 1 aabbcc 0 0 1",
                     bus.pix_valid, bus.pix_rgb, bus.pix_x, bus.pix_y, bus.sof);
        end
        checks++;
        if (bus.done !== 1'b0 || bus.frame_err !== 1'b0) begin
            failures++;
            $display("FAIL rstmid_status got done=%b err=%b exp 0 0", bus.done, bus.frame_err);
        end
    endtask

    initial begin
        bus.in_data  = 8'h00;
        bus.in_valid = 1'b0;
        bus.eof      = 1'b0;
        test_reset();
        test_single_pixel();
        test_frame();
        test_gaps();
        test_eof_clean();
        test_eof_short();
        test_eof_partial();
        test_rst_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
